coin_acceptor: RTL



---
 rtl/coin_acceptor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Synchronises and debounces three coin sensors, then issues one
//               registered 2-bit coin code per physical coin, or a reject.
// Revision    : 1.0
// ============================================================================
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sns_25,
    input  logic       sns_50,
    input  logic       sns_100,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic [7:0] acc_count
);

    localparam logic [7:0] C_DEB   = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] C_GAP   = 8'(GAP_CYCLES);
    localparam logic [7:0] C_STUCK = 8'(STUCK_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] cap_q, cap_d;
    logic [1:0] fill_q, fill_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] stuck_q, stuck_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] coin_q, coin_d;
    logic       reject_q, reject_d;
    logic       jam_q, jam_d;
    logic [2:0] sens;
    logic       cap_onehot;

    assign sens       = sync2_q;
    assign cap_onehot = (cap_q == 3'b001) || (cap_q == 3'b010) || (cap_q == 3'b100);

    // Release gap is not counted until the synchroniser has refilled after
    // reset, so a sensor held through reset cannot look like a clear gap.
    assign fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        stuck_d  = stuck_q;
        acc_d    = acc_q;
        jam_d    = jam_q;
        reject_d = 1'b0;
        coin_d   = 2'b11;
        case (state_q)
            IDLE: begin
                if (sens != 3'b000) begin
                    cap_d   = sens;
                    cnt_d   = 8'd1;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sens == 3'b000) begin
                    state_d = IDLE;
                end else if (sens != cap_q) begin
                    cap_d = sens;
                    cnt_d = 8'd1;
                end else if (cnt_q < C_DEB) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (cap_onehot && accept_en) begin
                    state_d = EMIT;
                end else begin
                    reject_d = 1'b1;
                    state_d  = WAIT_REL;
                end
            end
            EMIT: begin
                coin_d  = cap_q[2] ? 2'b10 : (cap_q[1] ? 2'b01 : 2'b00);
                acc_d   = acc_q + 8'd1;
                state_d = WAIT_REL;
            end
            default: begin
                if (sens != 3'b000) begin
                    gap_d = 8'd0;
                    if (stuck_q != 8'hFF) begin
                        stuck_d = stuck_q + 8'd1;
                    end
                    if (stuck_d >= C_STUCK) begin
                        jam_d = 1'b1;
                    end
                end else if (fill_q == 2'd2) begin
                    if (gap_q + 8'd1 >= C_GAP) begin
                        state_d = IDLE;
                        gap_d   = 8'd0;
                        stuck_d = 8'd0;
                        jam_d   = 1'b0;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            fill_q   <= 2'd0;
            state_q  <= WAIT_REL;
            cap_q    <= 3'b000;
            cnt_q    <= 8'd0;
            gap_q    <= 8'd0;
            stuck_q  <= 8'd0;
            acc_q    <= 8'd0;
            coin_q   <= 2'b11;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            sync1_q  <= {sns_100, sns_50, sns_25};
            sync2_q  <= sync1_q;
            fill_q   <= fill_d;
            state_q  <= state_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            stuck_q  <= stuck_d;
            acc_q    <= acc_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
            jam_q    <= jam_d;
        end
    end

    assign coin      = coin_q;
    assign reject    = reject_q;
    assign jam       = jam_q;
    assign acc_count = acc_q;

endmodule
`default_nettype wire
